// File: rtl/board_pixel_gen.sv
// Connect Four pixel generator.
// Draws the board grid, the placed pieces, the header cursor piece, a blinking
// highlight on the winning cells and the frame-paced drop of the last move.
// Two pipeline stages: stage 1 decodes geometry, stage 2 selects the colour.
// hsync/vsync are delayed by the same two cycles.
//
// Ports:
//   clk_d, rst_n                  pixel clock, async active-low reset
//   pixel_x, pixel_y, video_on    VGA timing coordinates and active flag
//   hsync_in, vsync_in            raw syncs
//   occ, clr, win_mask            per-cell state, index c*ROWS+r (r = 0 bottom)
//   cursor_col/en, player_colour  header cursor piece
//   drop_start/col/row/colour     drop animation request
//   red, green, blue              4-bit colour out
//   hsync_out, vsync_out          delayed syncs
//   drop_busy, drop_done          animation status / end pulse
module board_pixel_gen #(
  parameter int unsigned COLS         = 7,
  parameter int unsigned ROWS         = 6,
  parameter int unsigned CELL_W       = 89,
  parameter int unsigned CELL_H       = 66,
  parameter int unsigned LINE_W       = 2,
  parameter int unsigned HDR_H        = 68,
  parameter int unsigned FRAME_Y      = 480,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned DROP_STEP    = 8
) (
  input  logic                 clk_d,
  input  logic                 rst_n,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  input  logic                 video_on,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic [COLS*ROWS-1:0] occ,
  input  logic [COLS*ROWS-1:0] clr,
  input  logic [COLS*ROWS-1:0] win_mask,
  input  logic [2:0]           cursor_col,
  input  logic                 cursor_en,
  input  logic                 player_colour,
  input  logic                 drop_start,
  input  logic [2:0]           drop_col,
  input  logic [2:0]           drop_row,
  input  logic                 drop_colour,
  output logic [3:0]           red,
  output logic [3:0]           green,
  output logic [3:0]           blue,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic                 drop_busy,
  output logic                 drop_done
);

  localparam int unsigned P      = CELL_W + LINE_W;
  localparam int unsigned Q      = CELL_H + LINE_W;
  localparam int unsigned IdxW   = $clog2(COLS * ROWS);
  localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);

  localparam logic [11:0] ColBlack  = 12'h000;
  localparam logic [11:0] ColWhite  = 12'hFFF;
  localparam logic [11:0] ColBlue   = 12'h00F;
  localparam logic [11:0] ColRed    = 12'hF00;
  localparam logic [11:0] ColYellow = 12'hFF0;

  typedef enum logic [1:0] {StIdle, StFall, StLand} drop_state_e;

  // ---------------- Stage 1: geometry decode ----------------
  logic [10:0] x11, y11;
  logic        vline, hline, col_ok, row_ok;
  logic [2:0]  col_idx, row_t;

  assign x11 = {1'b0, pixel_x};
  assign y11 = {1'b0, pixel_y};

  always_comb begin
    vline   = 1'b0;
    hline   = 1'b0;
    col_ok  = 1'b0;
    col_idx = '0;
    row_ok  = 1'b0;
    row_t   = '0;
    for (int k = 0; k <= int'(COLS); k++) begin
      if (x11 >= 11'(k * P) && x11 <= 11'(k * P + LINE_W - 1)) vline = 1'b1;
    end
    for (int k = 0; k <= int'(ROWS); k++) begin
      if (y11 >= 11'(HDR_H + k * Q) && y11 <= 11'(HDR_H + k * Q + LINE_W - 1)) hline = 1'b1;
    end
    for (int k = 0; k < int'(COLS); k++) begin
      if (x11 >= 11'(k * P + LINE_W) && x11 <= 11'(k * P + LINE_W + CELL_W - 1)) begin
        col_ok  = 1'b1;
        col_idx = 3'(k);
      end
    end
    // row_t counts from the top of the board
    for (int k = 0; k < int'(ROWS); k++) begin
      if (y11 >= 11'(HDR_H + k * Q + LINE_W) && y11 <= 11'(HDR_H + k * Q + LINE_W + CELL_H - 1))
      begin
        row_ok = 1'b1;
        row_t  = 3'(k);
      end
    end
  end

  logic        s1_von, s1_hs, s1_vs, s1_grid, s1_col_ok, s1_row_ok, s1_hdr;
  logic [2:0]  s1_col, s1_row;
  logic [10:0] s1_y;

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      s1_von    <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_grid   <= 1'b0;
      s1_col_ok <= 1'b0;
      s1_row_ok <= 1'b0;
      s1_hdr    <= 1'b0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_y      <= '0;
    end else begin
      s1_von    <= video_on;
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
      s1_grid   <= hline | (vline & (y11 >= 11'(HDR_H)));
      s1_col_ok <= col_ok;
      s1_row_ok <= row_ok;
      s1_hdr    <= y11 < 11'(HDR_H);
      s1_col    <= col_idx;
      s1_row    <= row_t;
      s1_y      <= y11;
    end
  end

  // ---------------- Frame strobe, blink ----------------
  logic              frame_strobe;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_ph_q;

  assign frame_strobe = (pixel_x == 10'd0) && (pixel_y == 10'(FRAME_Y));

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (frame_strobe) begin
      if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        blink_ph_q  <= ~blink_ph_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // ---------------- Drop FSM ----------------
  drop_state_e state_q, state_d;
  logic [2:0]  drop_col_q, drop_col_d, drop_t_q, drop_t_d;
  logic        drop_clr_q, drop_clr_d, drop_done_q, drop_done_d;
  logic [10:0] drop_y_q, drop_y_d, tgt_y, step_y;

  assign tgt_y  = 11'(HDR_H + LINE_W) + 11'(Q) * 11'(drop_t_q);
  assign step_y = drop_y_q + 11'(DROP_STEP);

  always_comb begin
    state_d     = state_q;
    drop_col_d  = drop_col_q;
    drop_t_d    = drop_t_q;
    drop_clr_d  = drop_clr_q;
    drop_y_d    = drop_y_q;
    drop_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (drop_start && 32'(drop_col) < COLS && 32'(drop_row) < ROWS) begin
          drop_col_d = drop_col;
          drop_t_d   = 3'(ROWS - 1) - drop_row;
          drop_clr_d = drop_colour;
          drop_y_d   = '0;
          state_d    = StFall;
        end
      end
      StFall: begin
        if (frame_strobe) begin
          // clamp onto the landing position instead of overshooting it
          if (step_y >= tgt_y) begin
            drop_y_d = tgt_y;
            state_d  = StLand;
          end else begin
            drop_y_d = step_y;
          end
        end
      end
      StLand: begin
        if (frame_strobe) begin
          drop_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      drop_col_q  <= '0;
      drop_t_q    <= '0;
      drop_clr_q  <= 1'b0;
      drop_y_q    <= '0;
      drop_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_col_q  <= drop_col_d;
      drop_t_q    <= drop_t_d;
      drop_clr_q  <= drop_clr_d;
      drop_y_q    <= drop_y_d;
      drop_done_q <= drop_done_d;
    end
  end

  assign drop_busy = (state_q != StIdle);
  assign drop_done = drop_done_q;

  // ---------------- Stage 2: colour select ----------------
  logic [2:0]      cell_r;
  logic [IdxW-1:0] cell_idx;
  logic            in_piece, is_target;
  logic [11:0]     rgb_d, rgb_q;

  assign cell_r    = 3'(ROWS - 1) - s1_row;
  assign cell_idx  = IdxW'(s1_col) * IdxW'(ROWS) + IdxW'(cell_r);
  assign is_target = drop_busy && (s1_col == drop_col_q) && (s1_row == drop_t_q);
  assign in_piece  = drop_busy && s1_col_ok && (s1_col == drop_col_q) &&
                     (s1_y >= drop_y_q) && (s1_y <= drop_y_q + 11'(CELL_H - 1));

  always_comb begin
    rgb_d = ColBlack;
    if (!s1_von) begin
      rgb_d = ColBlack;
    end else if (s1_grid) begin
      rgb_d = ColWhite;
    end else if (in_piece) begin
      rgb_d = drop_clr_q ? ColRed : ColBlue;
    end else if (s1_col_ok && s1_row_ok) begin
      // the landing cell stays empty until the animation has finished
      if (is_target || !occ[cell_idx]) rgb_d = ColBlack;
      else if (win_mask[cell_idx] && blink_ph_q) rgb_d = ColYellow;
      else rgb_d = clr[cell_idx] ? ColRed : ColBlue;
    end else if (s1_hdr && s1_col_ok && (s1_col == cursor_col) && cursor_en) begin
      rgb_d = player_colour ? ColRed : ColBlue;
    end
  end

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q     <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb_q     <= rgb_d;
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
    end
  end

  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_board_pixel_gen.sv
// Bench for board_pixel_gen: streams directed and random pixels through the
// DUT and compares the delayed colour/sync, drop_busy and drop_done against an
// arithmetic model of the board (div/mod geometry, strobe-count blink).
module tb_board_pixel_gen;
  localparam int COLS = 7, ROWS = 6, CELL_W = 89, CELL_H = 66, LINE_W = 2, HDR_H = 68;
  localparam int FRAME_Y = 480, BLINK = 2, STEP = 8;
  localparam int P = CELL_W + LINE_W, Q = CELL_H + LINE_W;

  logic clk_d = 1'b0, rst_n = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [COLS*ROWS-1:0] occ = '0, clr = '0, win_mask = '0;
  logic [2:0] cursor_col = '0, drop_col = '0, drop_row = '0;
  logic cursor_en = 1'b0, player_colour = 1'b0, drop_start = 1'b0, drop_colour = 1'b0;
  logic [3:0] red, green, blue;
  logic hsync_out, vsync_out, drop_busy, drop_done;

  board_pixel_gen #(
    .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .CELL_H(CELL_H), .LINE_W(LINE_W),
    .HDR_H(HDR_H), .FRAME_Y(FRAME_Y), .BLINK_FRAMES(BLINK), .DROP_STEP(STEP)
  ) dut (
    .clk_d(clk_d), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .occ(occ), .clr(clr), .win_mask(win_mask), .cursor_col(cursor_col),
    .cursor_en(cursor_en), .player_colour(player_colour), .drop_start(drop_start),
    .drop_col(drop_col), .drop_row(drop_row), .drop_colour(drop_colour),
    .red(red), .green(green), .blue(blue), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .drop_busy(drop_busy), .drop_done(drop_done)
  );

  always #5 clk_d = ~clk_d;

  int total = 0, bad = 0;
  logic [13:0] pipe[$];
  bit m_busy, m_landed, m_done, m_clr;
  int m_y, m_col, m_row, m_strobes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(int x, int y, bit von);
    int cx, t, r, yy, idx;
    bit in_col, in_row;
    if (!von) return 12'h000;
    yy = y - HDR_H;
    if (y >= HDR_H && (x % P) < LINE_W && x / P <= COLS) return 12'hFFF;
    if (y >= HDR_H && (yy % Q) < LINE_W && yy / Q <= ROWS) return 12'hFFF;
    cx = x / P;
    in_col = (x % P) >= LINE_W && cx < COLS;
    if (m_busy && in_col && cx == m_col && y >= m_y && y <= m_y + CELL_H - 1)
      return m_clr ? 12'hF00 : 12'h00F;
    t = yy / Q;
    in_row = y >= HDR_H && (yy % Q) >= LINE_W && t < ROWS;
    if (in_col && in_row) begin
      r = ROWS - 1 - t;
      if (m_busy && cx == m_col && r == m_row) return 12'h000;
      idx = cx * ROWS + r;
      if (!occ[idx]) return 12'h000;
      if (win_mask[idx] && ((m_strobes / BLINK) % 2 == 1)) return 12'hFF0;
      return clr[idx] ? 12'hF00 : 12'h00F;
    end
    if (y < HDR_H && in_col && cx == int'(cursor_col) && cursor_en)
      return player_colour ? 12'hF00 : 12'h00F;
    return 12'h000;
  endfunction

  // One pixel per clock; the model reflects state after this edge, which is
  // what stage 2 sees when this pixel reaches it.
  task automatic step(input int x, input int y, input bit von);
    logic hs, vs;
    int tgt;
    bit strobe;
    hs = 1'($urandom);
    vs = 1'($urandom);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
    strobe = (x == 0 && y == FRAME_Y);
    m_done = 1'b0;
    if (!m_busy) begin
      if (drop_start && int'(drop_col) < COLS && int'(drop_row) < ROWS) begin
        m_busy = 1'b1;
        m_landed = 1'b0;
        m_y = 0;
        m_col = int'(drop_col);
        m_row = int'(drop_row);
        m_clr = drop_colour;
      end
    end else if (strobe) begin
      if (m_landed) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        tgt = HDR_H + (ROWS - 1 - m_row) * Q + LINE_W;
        m_y = (m_y + STEP < tgt) ? m_y + STEP : tgt;
        if (m_y == tgt) m_landed = 1'b1;
      end
    end
    if (strobe) m_strobes++;
    pipe.push_back({hs, vs, exp_rgb(x, y, von)});
    @(posedge clk_d);
    #1;
    if (pipe.size() >= 2) chk("pixel", 32'({hsync_out, vsync_out, red, green, blue}),
                              32'(pipe.pop_front()));
    chk("busy", 32'(drop_busy), 32'(m_busy));
    chk("done", 32'(drop_done), 32'(m_done));
  endtask

  task automatic rand_pix(input int n);
    for (int i = 0; i < n; i++)
      step(int'($urandom_range(639)), int'($urandom_range(479)), $urandom_range(7) != 0);
  endtask

  task automatic flush();
    step(1, 1, 1'b0);
    step(1, 1, 1'b0);
  endtask

  task automatic do_start(input int c, input int r, input bit k);
    drop_col = 3'(c);
    drop_row = 3'(r);
    drop_colour = k;
    drop_start = 1'b1;
    step(3, 3, 1'b0);
    drop_start = 1'b0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_landed = 0; m_done = 0; m_clr = 0;
    m_y = 0; m_col = 0; m_row = 0; m_strobes = 0;
    pipe.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int xs[16] = '{0, 1, 2, 90, 91, 92, 93, 181, 182, 183, 184, 400, 636, 637, 638, 639};
    int ys[12] = '{0, 67, 68, 69, 70, 136, 137, 138, 300, 477, 478, 479};
    int n, ndone;
    model_reset();
    // Reset state
    #12;
    chk("rst_rgb", 32'({red, green, blue}), 32'h0);
    chk("rst_sync", 32'({hsync_out, vsync_out}), 32'h0);
    chk("rst_busy", 32'(drop_busy), 32'h0);
    chk("rst_done", 32'(drop_done), 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk_d);
    #1;

    // Empty board, grid lines and lag
    foreach (ys[j]) foreach (xs[i]) step(xs[i], ys[j], 1'b1);
    rand_pix(300);

    // Two placed pieces and the cursor
    flush();
    occ[3*ROWS + 0] = 1'b1; clr[3*ROWS + 0] = 1'b1;
    occ[0*ROWS + 5] = 1'b1; clr[0*ROWS + 5] = 1'b0;
    cursor_en = 1'b1; cursor_col = 3'd4; player_colour = 1'b1;
    step(320, 440, 1'b1);
    step(40, 100, 1'b1);
    step(320, 440, 1'b0);
    step(4*P + 30, 20, 1'b1);
    rand_pix(200);

    // Blinking win line in column 3 rows 0..3, one non-win red piece
    flush();
    for (int r = 0; r < 4; r++) begin
      occ[3*ROWS + r] = 1'b1; clr[3*ROWS + r] = 1'b1; win_mask[3*ROWS + r] = 1'b1;
    end
    occ[6*ROWS + 2] = 1'b1; clr[6*ROWS + 2] = 1'b1;
    cursor_col = 3'd1; player_colour = 1'b0;
    for (int f = 0; f < 8; f++) begin
      step(0, FRAME_Y, 1'b1);
      step(320, 440, 1'b1);
      step(320, 370, 1'b1);
      step(40, 100, 1'b1);
      step(588, 304, 1'b1);
      rand_pix(10);
    end

    // Drop into column 2 row 0; a second request mid-fall must be ignored
    flush();
    occ[2*ROWS + 0] = 1'b1; clr[2*ROWS + 0] = 1'b1;
    do_start(2, 0, 1'b1);
    n = 0;
    ndone = 0;
    for (int i = 0; i < 70 && drop_busy; i++) begin
      step(0, FRAME_Y, 1'b1);
      n++;
      if (drop_done) ndone++;
      if (i == 10) do_start(5, 3, 1'b0);
      step(228, 443, 1'b1);
      step(228, m_y, 1'b1);
      step(228, m_y + CELL_H - 1, 1'b1);
      step(228, m_y + CELL_H, 1'b1);
      step(100, m_y + 3, 1'b1);
      step(5*P + 40, m_y + 3, 1'b1);
    end
    chk("strobes_to_idle", 32'(n), 32'd53);
    chk("done_pulses", 32'(ndone), 32'd1);
    step(228, 443, 1'b1);

    // Out-of-range requests in IDLE
    do_start(2, 6, 1'b1);
    step(0, FRAME_Y, 1'b1);
    do_start(7, 0, 1'b1);
    step(0, FRAME_Y, 1'b1);
    rand_pix(20);

    // Reset in the middle of a fall
    do_start(4, 2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(0, FRAME_Y, 1'b1);
      step(4*P + 12, m_y + 5, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb", 32'({red, green, blue}), 32'h0);
    chk("mid_rst_sync", 32'({hsync_out, vsync_out}), 32'h0);
    chk("mid_rst_busy", 32'(drop_busy), 32'h0);
    repeat (3) begin
      @(posedge clk_d);
      #1;
      chk("rst_hold_done", 32'(drop_done), 32'h0);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, FRAME_Y, 1'b1);
      rand_pix(5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
